// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared definitions for the multi-key debounce scheduler.
//   arb_state_e : scheduler FSM states (ST_SCAN / ST_LOCK)
//   CNT_W       : width of the shared debounce counter
//   id_w()      : width of a key index, never less than one bit
// ---------------------------------------------------------------------------
package key_pkg;

    localparam int CNT_W = 20;

    typedef enum logic {
        ST_SCAN = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    // A single key still needs a one-bit index so that key_id is never zero-width.
    function automatic int id_w(input int key_num);
        int w;
        w = $clog2(key_num);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/key_sync.sv
// ---------------------------------------------------------------------------
// key_sync
// Vector two-flop synchroniser for asynchronous inputs.
// Parameters:
//   WIDTH   : number of bits synchronised
//   RST_VAL : value both stages take during reset
// Ports:
//   clk_i   : destination clock
//   rst_n_i : asynchronous active-low reset
//   d_i     : asynchronous inputs
//   q_o     : synchronised outputs (two clock edges of delay)
// ---------------------------------------------------------------------------
module key_sync #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // First stage may go metastable; the second stage gives it a full cycle
    // to settle before anything downstream looks at the value.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/key_scan_arb.sv
// ---------------------------------------------------------------------------
// key_scan_arb
// Multi-key debounce scheduler. One shared counter is time-multiplexed over
// KEY_NUM keys: a round-robin scanner looks for a key whose synchronised level
// differs from its debounced level, then locks the counter onto that key until
// the new level has held for CNT_MAX cycles, and reports a one-cycle event.
//
// Parameters:
//   KEY_NUM : number of keys (2..16)
//   CNT_MAX : stable cycles required to accept a level change
// Ports:
//   sys_clk   : system clock
//   sys_rst_n : asynchronous active-low reset
//   key_in    : raw active-low keys, asynchronous to sys_clk
//   key_flag  : one-cycle event pulse
//   key_id    : index of the key the event refers to (holds until next event)
//   key_press : 1 = press, 0 = release (holds until next event)
//   key_state : debounced key levels
//   busy      : high in every cycle the counter is locked to a key
//
// Build option:
//   KEY_RELEASE_FLAG_EN : when defined, releases also pulse key_flag with
//                         key_press = 0; otherwise releases only update
//                         key_state and every reported event is a press.
// ---------------------------------------------------------------------------
module key_scan_arb
    import key_pkg::*;
#(
    parameter int               KEY_NUM = 4,
    parameter logic [CNT_W-1:0] CNT_MAX = 20'd999_999,
    localparam int              ID_W    = id_w(KEY_NUM)
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [KEY_NUM-1:0] key_in,
    output logic               key_flag,
    output logic [ID_W-1:0]    key_id,
    output logic               key_press,
    output logic [KEY_NUM-1:0] key_state,
    output logic               busy
);

    localparam logic [ID_W-1:0]  LAST_IDX = ID_W'(KEY_NUM - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - CNT_W'(1);

    logic [KEY_NUM-1:0] sync;

    arb_state_e         state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [KEY_NUM-1:0] key_state_q, key_state_d;
    logic               flag_q, flag_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               press_q, press_d;
    logic               busy_q, busy_d;

    // Wrapping increment; KEY_NUM need not be a power of two.
    function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + ID_W'(1);
    endfunction

    // Synchronisers reset to "released" so idle keys never look like presses.
    key_sync #(
        .WIDTH   (KEY_NUM),
        .RST_VAL ({KEY_NUM{1'b1}})
    ) u_key_sync (
        .clk_i   (sys_clk),
        .rst_n_i (sys_rst_n),
        .d_i     (key_in),
        .q_o     (sync)
    );

    // Scheduler next-state logic. SCAN walks the keys one per cycle looking
    // for a level change; LOCK watches only the selected key. A bounce back
    // abandons the count, a full count commits the new level. Either way the
    // scan resumes at the key after the one just served, so a chattering key
    // cannot monopolise the counter.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        key_state_d = key_state_q;
        flag_d      = 1'b0;
        id_d        = id_q;
        press_d     = press_q;

        case (state_q)
            ST_SCAN: begin
                if (sync[ptr_q] != key_state_q[ptr_q]) begin
                    state_d = ST_LOCK;
                    sel_d   = ptr_q;
                    cnt_d   = '0;
                end else begin
                    ptr_d = next_idx(ptr_q);
                end
            end
            ST_LOCK: begin
                if (sync[sel_q] == key_state_q[sel_q]) begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                    ptr_d   = next_idx(sel_q);
                end else if (cnt_q == CNT_LAST) begin
                    state_d            = ST_SCAN;
                    cnt_d              = '0;
                    ptr_d              = next_idx(sel_q);
                    key_state_d[sel_q] = sync[sel_q];
`ifdef KEY_RELEASE_FLAG_EN
                    flag_d  = 1'b1;
                    id_d    = sel_q;
                    press_d = ~sync[sel_q];
`else
                    // Releases are committed silently in this build.
                    if (!sync[sel_q]) begin
                        flag_d  = 1'b1;
                        id_d    = sel_q;
                        press_d = 1'b1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_SCAN;
            end
        endcase

        // busy is registered, so it follows the state being entered.
        busy_d = (state_d == ST_LOCK);
    end

    // State and output registers. Reset abandons any count in progress and
    // returns every key to the released level without emitting an event.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_SCAN;
            ptr_q       <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
            key_state_q <= '1;
            flag_q      <= 1'b0;
            id_q        <= '0;
            press_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            key_state_q <= key_state_d;
            flag_q      <= flag_d;
            id_q        <= id_d;
            press_q     <= press_d;
            busy_q      <= busy_d;
        end
    end

    assign key_flag  = flag_q;
    assign key_id    = id_q;
    assign key_press = press_q;
    assign key_state = key_state_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_key_scan_arb.sv
// ---------------------------------------------------------------------------
// tb_key_scan_arb
// Self-checking bench for key_scan_arb (KEY_NUM = 4, CNT_MAX = 24, 20 ns clock).
// A behavioural scheduler model tracks the debounced levels and expected
// events every cycle; directed scenarios add latency/order checks on top,
// followed by a randomized key-pattern phase.
// Honors KEY_RELEASE_FLAG_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_key_scan_arb;

    localparam int KEYS = 4;
    localparam int CMAX = 24;

    logic            sys_clk;
    logic            sys_rst_n;
    logic [KEYS-1:0] key_in;
    logic            key_flag;
    logic [1:0]      key_id;
    logic            key_press;
    logic [KEYS-1:0] key_state;
    logic            busy;

    int vectorCount = 0;
    int missCount   = 0;
    int cycleNo     = 0;

    // Observed event log of the current scenario.
    int flagCount;
    int flagCycle[$];
    int flagId[$];
    int flagPress[$];

    // Behavioural model state.
    logic [KEYS-1:0] mSync1, mSync2;
    logic [KEYS-1:0] mState;
    bit              mLocked;
    int              mPtr, mSel, mCnt;
    bit              mFlag;
    int              mId, mPress;

`ifdef KEY_RELEASE_FLAG_EN
    localparam bit RELEASE_EVENTS = 1'b1;
`else
    localparam bit RELEASE_EVENTS = 1'b0;
`endif

    key_scan_arb #(
        .KEY_NUM (KEYS),
        .CNT_MAX (20'd24)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_in    (key_in),
        .key_flag  (key_flag),
        .key_id    (key_id),
        .key_press (key_press),
        .key_state (key_state),
        .busy      (busy)
    );

    // 20 ns system clock.
    initial begin
        sys_clk = 1'b0;
        forever #10 sys_clk = ~sys_clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)",
                     tag, observed, expected, cycleNo);
        end
    endtask

    // Model reset: everything released, scanner idle at key 0.
    task automatic modelReset();
        mSync1  = '1;
        mSync2  = '1;
        mState  = '1;
        mLocked = 1'b0;
        mPtr    = 0;
        mSel    = 0;
        mCnt    = 0;
        mFlag   = 1'b0;
        mId     = 0;
        mPress  = 0;
    endtask

    // One clock of the scheduler rules, given the raw keys seen at this edge.
    // The level examined is the raw input from two edges earlier.
    task automatic modelStep(input logic [KEYS-1:0] keys);
        logic [KEYS-1:0] seen;
        seen  = mSync2;
        mFlag = 1'b0;
        if (!mLocked) begin
            if (seen[mPtr] != mState[mPtr]) begin
                mLocked = 1'b1;
                mSel    = mPtr;
                mCnt    = 0;
            end else begin
                mPtr = (mPtr + 1) % KEYS;
            end
        end else if (seen[mSel] == mState[mSel]) begin
            mLocked = 1'b0;
            mCnt    = 0;
            mPtr    = (mSel + 1) % KEYS;
        end else if (mCnt == CMAX - 1) begin
            mState[mSel] = seen[mSel];
            mLocked      = 1'b0;
            mCnt         = 0;
            mPtr         = (mSel + 1) % KEYS;
            if (seen[mSel] == 1'b0 || RELEASE_EVENTS) begin
                mFlag  = 1'b1;
                mId    = mSel;
                mPress = (seen[mSel] == 1'b0) ? 1 : 0;
            end
        end else begin
            mCnt = mCnt + 1;
        end
        mSync2 = mSync1;
        mSync1 = keys;
    endtask

    // Drive one cycle of key inputs, advance the model, compare at the
    // falling edge and log any event the DUT raised.
    task automatic applyStimulus(input logic [KEYS-1:0] keys);
        key_in = keys;
        @(posedge sys_clk);
        if (!sys_rst_n) modelReset();
        else            modelStep(keys);
        @(negedge sys_clk);
        cycleNo++;
        checkOutput("key_flag",  32'(key_flag),  32'(mFlag));
        checkOutput("key_state", 32'(key_state), 32'(mState));
        checkOutput("busy",      32'(busy),      32'(mLocked));
        checkOutput("key_id",    32'(key_id),    mId);
        checkOutput("key_press", 32'(key_press), mPress);
        if (key_flag) begin
            flagCount++;
            flagCycle.push_back(cycleNo);
            flagId.push_back(int'(key_id));
            flagPress.push_back(int'(key_press));
        end
    endtask

    task automatic clearLog();
        flagCount = 0;
        flagCycle.delete();
        flagId.delete();
        flagPress.delete();
    endtask

    initial begin
        int start;
        int lastHigh;
        int waited;
        logic [KEYS-1:0] k;
        logic [KEYS-1:0] hold;

        modelReset();
        key_in    = '1;
        sys_rst_n = 1'b0;
        clearLog();

        // Reset held: outputs at reset values.
        repeat (3) applyStimulus(4'hF);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Idle after reset: no events, never busy, all keys released.
        $display("[TB] idle after reset");
        repeat (200) applyStimulus(4'hF);
        checkOutput("idle_flags", flagCount, 0);
        checkOutput("idle_state", 32'(key_state), 32'hF);

        // Clean press of key 2.
        $display("[TB] clean press key 2");
        clearLog();
        start = cycleNo;
        repeat (40) applyStimulus(4'b1011);
        checkOutput("k2_flags", flagCount, 1);
        if (flagCount >= 1) begin
            checkOutput("k2_id", flagId[0], 2);
            checkOutput("k2_press", flagPress[0], 1);
            checkOutput("k2_latency_ok", 32'(flagCycle[0] - start <= 2 + KEYS + CMAX + 1), 1);
        end
        checkOutput("k2_state", 32'(key_state), 32'hB);

        // Bouncing key 1, then held low.
        $display("[TB] bouncing key 1");
        clearLog();
        lastHigh = cycleNo;
        for (int i = 0; i < 10; i++) begin
            k    = 4'b1011;
            k[1] = 1'($urandom % 2);
            applyStimulus(k);
            if (k[1]) lastHigh = cycleNo;
        end
        checkOutput("k1_bounce_flags", flagCount, 0);
        repeat (60) applyStimulus(4'b1001);
        checkOutput("k1_flags", flagCount, 1);
        if (flagCount >= 1) begin
            checkOutput("k1_id", flagId[0], 1);
            checkOutput("k1_gap_ok", 32'(flagCycle[0] - lastHigh >= CMAX), 1);
        end
        checkOutput("k1_state", 32'(key_state), 32'h9);

        // Release key 2 (key 1 still held).
        $display("[TB] release key 2");
        clearLog();
        repeat (40) applyStimulus(4'b1101);
        checkOutput("k2_rel_flags", flagCount, RELEASE_EVENTS ? 1 : 0);
        if (RELEASE_EVENTS && flagCount >= 1) begin
            checkOutput("k2_rel_id", flagId[0], 2);
            checkOutput("k2_rel_press", flagPress[0], 0);
        end
        checkOutput("k2_rel_state", 32'(key_state), 32'hD);
        repeat (40) applyStimulus(4'hF);
        checkOutput("all_rel_state", 32'(key_state), 32'hF);

        // Keys 0 and 3 together, timed so the scanner reaches them at ptr 0.
        $display("[TB] simultaneous keys 0 and 3");
        waited = 0;
        while (!(mPtr == 2 && !mLocked) && waited < 10) begin
            applyStimulus(4'hF);
            waited++;
        end
        checkOutput("ptr_align_in_time", 32'(waited < 10), 1);
        clearLog();
        repeat (80) applyStimulus(4'b0110);
        checkOutput("k03_flags", flagCount, 2);
        if (flagCount >= 2) begin
            checkOutput("k03_first_id", flagId[0], 0);
            checkOutput("k03_second_id", flagId[1], 3);
            checkOutput("k03_gap_ok", 32'(flagCycle[1] - flagCycle[0] >= CMAX + 1), 1);
        end
        checkOutput("k03_state", 32'(key_state), 32'h6);
        repeat (80) applyStimulus(4'hF);

        // Reset during LOCK at count 10.
        $display("[TB] reset during lock");
        waited = 0;
        while (!(mLocked && mCnt == 10) && waited < 40) begin
            applyStimulus(4'b1101);
            waited++;
        end
        checkOutput("lock_reached", 32'(waited < 40), 1);
        sys_rst_n = 1'b0;
        #1;
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_flag", 32'(key_flag), 0);
        checkOutput("rst_state", 32'(key_state), 32'hF);
        clearLog();
        repeat (3) applyStimulus(4'b1101);
        checkOutput("rst_no_event", flagCount, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (40) applyStimulus(4'hF);

        // Randomized key patterns, each held for a random duration.
        $display("[TB] random phase");
        for (int s = 0; s < 40; s++) begin
            hold = 4'($urandom);
            repeat ($urandom_range(1, 60)) applyStimulus(hold);
        end
        repeat (150) applyStimulus(4'hF);
        checkOutput("final_state", 32'(key_state), 32'hF);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
